// File: rtl/bcd_counter_n.sv
// bcd_counter_n
// Parametrised N-digit packed-BCD up/down counter with parallel load,
// programmable wrap limit, terminal-count pulse and load validation.
// Digit k of every packed BCD bus lives in bits [4k+3:4k].

module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] max_value,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         load_err
);

  // ---------------------------------------------------------------------------
  // BCD helper functions
  // ---------------------------------------------------------------------------

  // True when every digit of v is in 0..9.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Value with every digit set to 9 (largest representable count).
  function automatic logic [W-1:0] bcd_all_nines();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decimal increment with carry across all digits in one cycle.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   d;
    r     = '0;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*k +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  // Decimal decrement with borrow across all digits in one cycle.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = '0;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*k +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*k +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] lim_s;
  logic         load_ok_s;
  logic         at_zero_s;
  logic         ge_lim_s;
  logic         gt_lim_s;

  // Effective wrap limit: a malformed max_value falls back to all nines.
  // For valid packed BCD, unsigned binary order equals decimal order, so
  // plain magnitude comparisons are used below.
  always_comb begin
    if (bcd_valid(max_value)) begin
      lim_s = max_value;
    end else begin
      lim_s = bcd_all_nines();
    end
  end

  // Load validation and count-versus-limit comparisons.
  always_comb begin
    load_ok_s = bcd_valid(load_value) && (load_value <= lim_s);
    at_zero_s = (count_q == {W{1'b0}});
    ge_lim_s  = (count_q >= lim_s);
    gt_lim_s  = (count_q >  lim_s);
  end

  // Next-state selection: load has priority over enable, otherwise hold.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        count_d    = load_value;
        load_err_d = 1'b0;
      end else begin
        count_d    = count_q;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        // ">=" also recovers from a limit lowered below the current count.
        if (ge_lim_s) begin
          count_d = {W{1'b0}};
          tc_d    = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
          tc_d    = 1'b0;
        end
      end else begin
        if (at_zero_s) begin
          count_d = lim_s;
          tc_d    = 1'b1;
        end else if (gt_lim_s) begin
          // Limit was lowered: clamp to it without signalling a wrap.
          count_d = lim_s;
          tc_d    = 1'b0;
        end else begin
          count_d = bcd_dec(count_q);
          tc_d    = 1'b0;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= {W{1'b0}};
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n with DIGITS = 4.

module tb_bcd_counter_n;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] max_value;
  logic [15:0] count;
  logic        tc;
  logic        load_err;

  int n_checks;
  int n_fail;
  int e;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_value (load_value),
    .max_value  (max_value),
    .count      (count),
    .tc         (tc),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal integer to packed 4-digit BCD.
  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int m;
    m = n;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all three outputs at once.
  task automatic chk3(input string tag, input logic [15:0] c, input logic t, input logic le);
    chk({tag, ".count"}, count, c);
    chk({tag, ".tc"}, {15'd0, tc}, {15'd0, t});
    chk({tag, ".load_err"}, {15'd0, load_err}, {15'd0, le});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    en         = 1'b0;
    up_dn      = 1'b1;
    load       = 1'b0;
    load_value = 16'h0000;
    max_value  = 16'h9999;
    tick();
    tick();
    chk3("reset", 16'h0000, 1'b0, 1'b0);
    reset_n = 1'b1;

    // 1: count up 100 steps, carry across digits, no tc.
    en = 1'b1;
    up_dn = 1'b1;
    e = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      e++;
      chk("up100.count", count, to_bcd(e));
      chk("up100.tc", {15'd0, tc}, 16'h0000);
    end
    chk("up100.final", count, 16'h0100);

    // 2: wrap at 9999.
    en = 1'b0;
    load = 1'b1;
    load_value = 16'h9998;
    tick();
    chk3("ld9998", 16'h9998, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    tick();
    chk3("up9999", 16'h9999, 1'b0, 1'b0);
    tick();
    chk3("wrap0", 16'h0000, 1'b1, 1'b0);
    tick();
    chk3("after_wrap", 16'h0001, 1'b0, 1'b0);

    // 3: down-wrap from 0, then immediate direction flip.
    reset_n = 1'b0;
    #1;
    chk3("rst2", 16'h0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    up_dn = 1'b0;
    tick();
    chk3("dnwrap", 16'h9999, 1'b1, 1'b0);
    up_dn = 1'b1;
    tick();
    chk3("flipup", 16'h0000, 1'b1, 1'b0);

    // 4: programmable limit 59, lowering the limit.
    en = 1'b0;
    max_value = 16'h0059;
    load = 1'b1;
    load_value = 16'h0058;
    tick();
    chk3("ld58", 16'h0058, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    tick();
    chk3("up59", 16'h0059, 1'b0, 1'b0);
    tick();
    chk3("wrap59", 16'h0000, 1'b1, 1'b0);
    en = 1'b0;
    load = 1'b1;
    load_value = 16'h0045;
    tick();
    chk3("ld45a", 16'h0045, 1'b0, 1'b0);
    load = 1'b0;
    max_value = 16'h0030;
    tick();
    chk3("hold_lowered", 16'h0045, 1'b0, 1'b0);
    en = 1'b1;
    up_dn = 1'b1;
    tick();
    chk3("up_over_lim", 16'h0000, 1'b1, 1'b0);
    en = 1'b0;
    max_value = 16'h0059;
    load = 1'b1;
    load_value = 16'h0045;
    tick();
    chk3("ld45b", 16'h0045, 1'b0, 1'b0);
    load = 1'b0;
    max_value = 16'h0030;
    en = 1'b1;
    up_dn = 1'b0;
    tick();
    chk3("dn_clamp", 16'h0030, 1'b0, 1'b0);
    tick();
    chk3("dn_after_clamp", 16'h0029, 1'b0, 1'b0);

    // Malformed max_value falls back to 9999.
    en = 1'b0;
    max_value = 16'h00A0;
    load = 1'b1;
    load_value = 16'h5000;
    tick();
    chk3("badmax_ld", 16'h5000, 1'b0, 1'b0);
    load = 1'b0;
    load_value = 16'h0000;
    tick();
    en = 1'b1;
    up_dn = 1'b0;
    load = 1'b1;
    load_value = 16'h0000;
    tick();
    load = 1'b0;
    tick();
    chk3("badmax_dnwrap", 16'h9999, 1'b1, 1'b0);

    // 5: load validation.
    en = 1'b0;
    max_value = 16'h9999;
    load = 1'b1;
    load_value = 16'h0030;
    tick();
    chk3("ld30", 16'h0030, 1'b0, 1'b0);
    load_value = 16'h12A4;
    tick();
    chk3("ld_baddigit", 16'h0030, 1'b0, 1'b1);
    load = 1'b0;
    tick();
    chk3("hold_clr_err", 16'h0030, 1'b0, 1'b0);
    max_value = 16'h0059;
    load = 1'b1;
    load_value = 16'h0060;
    tick();
    chk3("ld_overlim", 16'h0030, 1'b0, 1'b1);
    load_value = 16'h0059;
    tick();
    chk3("ld_eqlim", 16'h0059, 1'b0, 1'b0);
    load_value = 16'h0042;
    en = 1'b1;
    up_dn = 1'b1;
    tick();
    chk3("ld_wins", 16'h0042, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk3("step43", 16'h0043, 1'b0, 1'b0);

    // 6: asynchronous reset mid-cycle while counting.
    tick();
    chk3("step44", 16'h0044, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk3("async_rst", 16'h0000, 1'b0, 1'b0);
    tick();
    chk3("rst_held", 16'h0000, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    tick();
    chk3("resume", 16'h0001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
